// File: rtl/calc_pkg.sv
// calc_pkg: key codes, operator/state/error encodings shared by the calculator
package calc_pkg;

    localparam logic [3:0] KEY_CLR = 4'hA;
    localparam logic [3:0] KEY_EXE = 4'hB;
    localparam logic [3:0] KEY_DIV = 4'hC;
    localparam logic [3:0] KEY_MUL = 4'hD;
    localparam logic [3:0] KEY_SUB = 4'hE;
    localparam logic [3:0] KEY_ADD = 4'hF;

    typedef enum logic [1:0] {OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2, OP_DIV = 2'd3} op_e;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTER_A = 3'd1,
        S_OPER    = 3'd2,
        S_ENTER_B = 3'd3,
        S_CALC    = 3'd4,
        S_RESULT  = 3'd5,
        S_ERROR   = 3'd6
    } state_e;

    typedef enum logic [1:0] {ERR_NONE = 2'b00, ERR_DIV0 = 2'b01, ERR_CHAIN = 2'b10} err_e;

    // Operator keys C..F map to div..add, which is the inverse of the low two code bits
    function automatic op_e key_to_op(input logic [3:0] k);
        return op_e'(~k[1:0]);
    endfunction

endpackage

// File: rtl/calc_controller_seq_divider.sv
// seq_divider: restoring unsigned divider producing one quotient bit per cycle
module seq_divider #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             abort,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, src_rem, src_quo;
    logic [WIDTH:0]   trial;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             run_q, run_d, done_q, done_d, step, ge;

    // One restoring step per cycle; start folds the first step into the operand load
    always_comb begin
        step    = start | run_q;
        src_rem = start ? '0 : rem_q;
        src_quo = start ? dividend : quo_q;
        trial   = {src_rem, src_quo[WIDTH-1]};
        ge      = trial >= {1'b0, divisor};
        rem_d   = step ? (ge ? WIDTH'(trial - {1'b0, divisor}) : trial[WIDTH-1:0]) : rem_q;
        quo_d   = step ? {src_quo[WIDTH-2:0], ge} : quo_q;
        cnt_d   = start ? CW'(WIDTH - 1) : (run_q ? cnt_q - 1'b1 : cnt_q);
        run_d   = start ? (WIDTH > 1) : (run_q && cnt_q > CW'(1));
        done_d  = start ? (WIDTH == 1) : (run_q && cnt_q == CW'(1));
    end

    // Divider registers; abort drops any division in flight
    always_ff @(posedge clk) begin
        if (abort) begin
            rem_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign quotient = quo_q;
    assign done     = done_q;

endmodule

// File: rtl/calc_controller.sv
// calc_controller: keypad calculator assembling signed operands and running add/sub/mul/div
module calc_controller
    import calc_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int WIDTH  = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               key_valid,
    input  logic [3:0]         key_code,
    input  logic               neg_a,
    input  logic               neg_b,
    output logic [2:0]         state_o,
    output logic [1:0]         op_o,
    output logic [WIDTH-1:0]   a_mag,
    output logic               a_neg,
    output logic [WIDTH-1:0]   b_mag,
    output logic               b_neg,
    output logic [2*WIDTH-1:0] res_mag,
    output logic               res_neg,
    output logic [2*WIDTH-1:0] disp_mag,
    output logic               disp_neg,
    output logic               busy,
    output logic [1:0]         err_o
);

    localparam int CW  = $clog2(DIGITS + 1);
    localparam int RMW = 2 * WIDTH;
    localparam int RW  = 2 * WIDTH + 1;

    if (10 ** DIGITS - 1 >= 2 ** WIDTH) begin : g_width_check
        $error("calc_controller: WIDTH cannot hold DIGITS decimal digits");
    end

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    err_e               err_q, err_d;
    logic [WIDTH-1:0]   a_mag_q, a_mag_d, b_mag_q, b_mag_d, dig, div_quo;
    logic               a_neg_q, a_neg_d, b_neg_q, b_neg_d, res_neg_q, res_neg_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [RMW-1:0]     res_mag_q, res_mag_d, disp_mag_q, disp_mag_d, calc_mag;
    logic               disp_neg_q, disp_neg_d, calc_neg;
    logic               key_prev_q, was_calc_q, was_calc_d;
    logic               ev, is_dig, is_op, is_exe, is_clr, div_start, div_done;
    logic signed [RW-1:0] sa, sb, sr, sabs;

    seq_divider #(.WIDTH(WIDTH)) u_div (
        .clk      (clk),
        .abort    (reset | is_clr),
        .start    (div_start),
        .dividend (a_mag_q),
        .divisor  (b_mag_q),
        .quotient (div_quo),
        .done     (div_done)
    );

    // Key decode, signed arithmetic, next-state/operand update and display select
    always_comb begin
        ev         = key_valid & ~key_prev_q;
        is_dig     = ev && key_code <= 4'd9;
        is_op      = ev && key_code >= KEY_DIV;
        is_exe     = ev && key_code == KEY_EXE;
        is_clr     = ev && key_code == KEY_CLR;
        dig        = WIDTH'(key_code);
        sa         = a_neg_q ? -RW'(a_mag_q) : RW'(a_mag_q);
        sb         = b_neg_q ? -RW'(b_mag_q) : RW'(b_mag_q);
        sr         = op_q == OP_ADD ? sa + sb : op_q == OP_SUB ? sa - sb : sa * sb;
        sabs       = sr[RW-1] ? -sr : sr;
        calc_mag   = RMW'(sabs);
        calc_neg   = sr[RW-1];
        was_calc_d = state_q == S_CALC;
        div_start  = state_q == S_CALC && op_q == OP_DIV && b_mag_q != '0 && !was_calc_q;
        state_d    = state_q;
        op_d       = op_q;
        err_d      = err_q;
        a_mag_d    = a_mag_q;
        a_neg_d    = a_neg_q;
        b_mag_d    = b_mag_q;
        b_neg_d    = b_neg_q;
        cnt_d      = cnt_q;
        res_mag_d  = res_mag_q;
        res_neg_d  = res_neg_q;
        case (state_q)
            S_IDLE, S_RESULT: begin
                if (is_dig) begin
                    state_d   = S_ENTER_A;
                    a_mag_d   = dig;
                    a_neg_d   = neg_a;
                    cnt_d     = CW'(1);
                    res_mag_d = '0;
                    res_neg_d = 1'b0;
                end else if (is_op && state_q == S_IDLE) begin
                    state_d = S_OPER;
                    a_mag_d = '0;
                    a_neg_d = 1'b0;
                    op_d    = key_to_op(key_code);
                end else if (is_op) begin
                    if (res_mag_q[RMW-1:WIDTH] == '0) begin
                        state_d = S_OPER;
                        a_mag_d = WIDTH'(res_mag_q);
                        a_neg_d = res_neg_q;
                        op_d    = key_to_op(key_code);
                        cnt_d   = '0;
                    end else begin
                        state_d = S_ERROR;
                        err_d   = ERR_CHAIN;
                    end
                end
            end
            S_ENTER_A: begin
                if (is_dig) begin
                    a_neg_d = neg_a;
                    if (cnt_q < CW'(DIGITS)) begin
                        a_mag_d = WIDTH'(a_mag_q * 10 + key_code);
                        cnt_d   = cnt_q + 1'b1;
                    end
                end else if (is_op) begin
                    state_d = S_OPER;
                    op_d    = key_to_op(key_code);
                    cnt_d   = '0;
                end
            end
            S_OPER: begin
                if (is_dig) begin
                    state_d = S_ENTER_B;
                    b_mag_d = dig;
                    b_neg_d = neg_b;
                    cnt_d   = CW'(1);
                end else if (is_op) begin
                    op_d = key_to_op(key_code);
                end
            end
            S_ENTER_B: begin
                if (is_dig) begin
                    b_neg_d = neg_b;
                    if (cnt_q < CW'(DIGITS)) begin
                        b_mag_d = WIDTH'(b_mag_q * 10 + key_code);
                        cnt_d   = cnt_q + 1'b1;
                    end
                end else if (is_exe) begin
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (op_q != OP_DIV) begin
                    state_d   = S_RESULT;
                    res_mag_d = calc_mag;
                    res_neg_d = calc_neg;
                end else if (b_mag_q == '0) begin
                    state_d = S_ERROR;
                    err_d   = ERR_DIV0;
                end else if (div_done) begin
                    state_d   = S_RESULT;
                    res_mag_d = RMW'(div_quo);
                    res_neg_d = (a_neg_q ^ b_neg_q) && div_quo != '0;
                end
            end
            S_ERROR: ;
            default: state_d = S_IDLE;
        endcase
        if (is_clr) begin
            state_d   = S_IDLE;
            op_d      = OP_ADD;
            err_d     = ERR_NONE;
            a_mag_d   = '0;
            a_neg_d   = 1'b0;
            b_mag_d   = '0;
            b_neg_d   = 1'b0;
            cnt_d     = '0;
            res_mag_d = '0;
            res_neg_d = 1'b0;
        end
        disp_mag_d = state_q == S_ENTER_B ? RMW'(b_mag_q) :
                     state_q == S_CALC    ? disp_mag_q :
                     state_q == S_RESULT  ? res_mag_q :
                     state_q == S_ERROR   ? '0 : RMW'(a_mag_q);
        disp_neg_d = state_q == S_ENTER_B ? b_neg_q :
                     state_q == S_CALC    ? disp_neg_q :
                     state_q == S_RESULT  ? res_neg_q :
                     state_q == S_ERROR   ? 1'b0 : a_neg_q;
    end

    // Controller registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            op_q       <= OP_ADD;
            err_q      <= ERR_NONE;
            a_mag_q    <= '0;
            a_neg_q    <= 1'b0;
            b_mag_q    <= '0;
            b_neg_q    <= 1'b0;
            cnt_q      <= '0;
            res_mag_q  <= '0;
            res_neg_q  <= 1'b0;
            disp_mag_q <= '0;
            disp_neg_q <= 1'b0;
            key_prev_q <= 1'b0;
            was_calc_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            err_q      <= err_d;
            a_mag_q    <= a_mag_d;
            a_neg_q    <= a_neg_d;
            b_mag_q    <= b_mag_d;
            b_neg_q    <= b_neg_d;
            cnt_q      <= cnt_d;
            res_mag_q  <= res_mag_d;
            res_neg_q  <= res_neg_d;
            disp_mag_q <= disp_mag_d;
            disp_neg_q <= disp_neg_d;
            key_prev_q <= key_valid;
            was_calc_q <= was_calc_d;
        end
    end

    assign state_o  = state_q;
    assign op_o     = op_q;
    assign err_o    = err_q;
    assign a_mag    = a_mag_q;
    assign a_neg    = a_neg_q;
    assign b_mag    = b_mag_q;
    assign b_neg    = b_neg_q;
    assign res_mag  = res_mag_q;
    assign res_neg  = res_neg_q;
    assign disp_mag = disp_mag_d;
    assign disp_neg = disp_neg_d;
    assign busy     = state_q == S_CALC;

endmodule

// File: tb/tb_calc_controller.sv
// tb_calc_controller: directed and randomized checks of the keypad calculator
module tb_calc_controller;

    localparam int DIGITS = 3;
    localparam int WIDTH  = 10;

    logic               clk = 1'b0;
    logic               reset, key_valid, neg_a, neg_b;
    logic [3:0]         key_code;
    logic [2:0]         state_o;
    logic [1:0]         op_o, err_o;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               a_neg, b_neg, res_neg, disp_neg, busy;
    logic [2*WIDTH-1:0] res_mag, disp_mag;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    calc_controller #(.DIGITS(DIGITS), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .key_valid(key_valid),
        .key_code (key_code),
        .neg_a    (neg_a),
        .neg_b    (neg_b),
        .state_o  (state_o),
        .op_o     (op_o),
        .a_mag    (a_mag),
        .a_neg    (a_neg),
        .b_mag    (b_mag),
        .b_neg    (b_neg),
        .res_mag  (res_mag),
        .res_neg  (res_neg),
        .disp_mag (disp_mag),
        .disp_neg (disp_neg),
        .busy     (busy),
        .err_o    (err_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One key event: held for one cycle, released, returns on the negedge after the acting edge
    task automatic press(input logic [3:0] k);
        @(negedge clk);
        key_code  = k;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    // Counts busy cycles (sampled at negedges) until busy drops, bounded
    task automatic wait_idle(output int n);
        n = 0;
        for (int i = 0; i < 40 && busy; i++) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int     n, na, nb, d, opk;
        longint av, bv, sa, sb, r, mag;
        logic   an, bn, bz, dz;

        reset = 1'b1; key_valid = 1'b0; key_code = 4'h0; neg_a = 1'b0; neg_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_state", state_o, 0);
        chk("rst_disp", disp_mag, 0);
        reset = 1'b0;

        press(4'd1); press(4'd2);
        chk("mid_entry_a", a_mag, 12);
        chk("mid_entry_state", state_o, 1);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk("mid_rst_state", state_o, 0);
        chk("mid_rst_a", a_mag, 0);
        chk("mid_rst_err", err_o, 0);
        chk("mid_rst_busy", busy, 0);

        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        chk("digit_limit", a_mag, 123);
        press(4'hF);
        chk("oper_state", state_o, 2);
        chk("oper_op", op_o, 0);
        press(4'd5);
        chk("b_entry", b_mag, 5);
        chk("disp_b", disp_mag, 5);
        press(4'hB);
        chk("calc_busy", busy, 1);
        wait_idle(n);
        chk("add_busy_cycles", n, 1);
        chk("add_state", state_o, 5);
        chk("add_res", res_mag, 128);
        chk("add_neg", res_neg, 0);
        chk("add_disp", disp_mag, 128);

        press(4'hA);
        neg_a = 1'b1;
        press(4'd7); press(4'hE); press(4'd9); press(4'hB);
        wait_idle(n);
        chk("sub_res", res_mag, 16);
        chk("sub_neg", res_neg, 1);
        press(4'hF);
        chk("chain_state", state_o, 2);
        chk("chain_a", a_mag, 16);
        chk("chain_aneg", a_neg, 1);
        press(4'd4); press(4'hB);
        wait_idle(n);
        chk("chain_res", res_mag, 12);
        chk("chain_neg", res_neg, 1);

        press(4'hA);
        neg_a = 1'b0;
        press(4'd9); press(4'd9); press(4'd9); press(4'hD);
        press(4'd9); press(4'd9); press(4'd9); press(4'hB);
        wait_idle(n);
        chk("mul_res", res_mag, 998001);
        press(4'hF);
        chk("ovf_state", state_o, 6);
        chk("ovf_err", err_o, 2);
        chk("ovf_disp", disp_mag, 0);
        press(4'd3);
        chk("err_ignore", state_o, 6);
        press(4'hA);
        chk("clr_state", state_o, 0);
        chk("clr_a", a_mag, 0);
        chk("clr_b", b_mag, 0);
        chk("clr_res", res_mag, 0);
        chk("clr_err", err_o, 0);

        neg_b = 1'b1;
        press(4'd1); press(4'd0); press(4'd0); press(4'hC); press(4'd7); press(4'hB);
        wait_idle(n);
        chk("div_busy_cycles", n, WIDTH + 1);
        chk("div_res", res_mag, 14);
        chk("div_neg", res_neg, 1);
        press(4'hA);
        press(4'd1); press(4'd0); press(4'd0); press(4'hC); press(4'd7); press(4'hB);
        repeat (3) @(negedge clk);
        chk("abort_busy_before", busy, 1);
        press(4'hA);
        chk("abort_state", state_o, 0);
        chk("abort_busy", busy, 0);
        chk("abort_res", res_mag, 0);
        repeat (15) @(negedge clk);
        chk("abort_quiet", state_o, 0);

        neg_b = 1'b0;
        press(4'd5); press(4'hC); press(4'd0); press(4'hB);
        wait_idle(n);
        chk("div0_state", state_o, 6);
        chk("div0_err", err_o, 1);
        chk("div0_disp", disp_mag, 0);
        press(4'hA);

        @(negedge clk);
        key_code = 4'd5; key_valid = 1'b1;
        repeat (50) @(negedge clk);
        key_valid = 1'b0;
        @(negedge clk);
        chk("hold_a", a_mag, 5);
        chk("hold_state", state_o, 1);

        for (int it = 0; it < 30; it++) begin
            press(4'hA);
            neg_a = 1'($urandom_range(0, 1));
            na = $urandom_range(1, 4);
            av = 0;
            for (int j = 0; j < na; j++) begin
                d = $urandom_range(0, 9);
                press(4'(d));
                if (j < DIGITS) av = av * 10 + d;
            end
            an = neg_a;
            opk = $urandom_range(12, 15);
            press(4'(opk));
            neg_b = 1'($urandom_range(0, 1));
            bz = $urandom_range(0, 3) == 0;
            nb = $urandom_range(1, 4);
            bv = 0;
            for (int j = 0; j < nb; j++) begin
                d = bz ? 0 : $urandom_range(0, 9);
                press(4'(d));
                if (j < DIGITS) bv = bv * 10 + d;
            end
            bn = neg_b;
            chk("rnd_a", a_mag, av);
            chk("rnd_b", b_mag, bv);
            press(4'hB);
            wait_idle(n);
            chk("rnd_busy_done", busy, 0);
            sa = an ? -av : av;
            sb = bn ? -bv : bv;
            dz = opk == 12 && bv == 0;
            r = opk == 15 ? sa + sb : opk == 14 ? sa - sb : opk == 13 ? sa * sb : (dz ? 0 : sa / sb);
            mag = r < 0 ? -r : r;
            if (dz) begin
                chk("rnd_div0_state", state_o, 6);
                chk("rnd_div0_err", err_o, 1);
            end else begin
                chk("rnd_state", state_o, 5);
                chk("rnd_res", res_mag, mag);
                chk("rnd_neg", res_neg, r < 0);
                chk("rnd_busy_cycles", n, opk == 12 ? WIDTH + 1 : 1);
                if ($urandom_range(0, 1) == 1) begin
                    opk = $urandom_range(12, 15);
                    press(4'(opk));
                    if (mag < (1 << WIDTH)) begin
                        chk("rnd_chain_state", state_o, 2);
                        chk("rnd_chain_a", a_mag, mag);
                        chk("rnd_chain_aneg", a_neg, r < 0);
                        chk("rnd_chain_op", op_o, 15 - opk);
                    end else begin
                        chk("rnd_chain_ovf_state", state_o, 6);
                        chk("rnd_chain_ovf_err", err_o, 2);
                    end
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
